// File: rtl/demod_error_monitor.sv
// -----------------------------------------------------------------------------
// demod_error_monitor
//   Compares a demodulator under test against a reference demodulator, one
//   independent lane per channel. Each lane aligns the two sample streams in
//   arrival order through a pair of FIFOs, squares the difference and reports
//   the mean-square error once per 2^WINDOW_LOG2 pairs.
//
// Ports (top):
//   clk, reset           clock, synchronous active-high reset
//   enable_i             high = monitor runs, low = flush and idle
//   clear_i              pulse, clears sticky fail_o / overflow_o
//   threshold_msq_i      mean-square threshold, LSB^2 (2*DW bits)
//   dut_data_i/valid_i   DUT samples, channel c at [c*DW +: DW]
//   ref_data_i/valid_i   reference samples, same packing
//   msq_o                last completed window mean-square, 2*DW per channel
//   msq_valid_o          one-cycle pulse per channel when msq_o updates
//   fail_o               sticky, some window exceeded the threshold
//   overflow_o           sticky, a sample was dropped on a full FIFO
//   window_count_o       windows completed on channel 0 (wraps)
// -----------------------------------------------------------------------------

// First-word-fall-through FIFO. The caller only asserts push when the write is
// legal (not full, or a pop in the same cycle) and pop only when not empty.
module demod_err_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// -----------------------------------------------------------------------------
// One monitor lane: alignment FIFOs, sequencing FSM, error pipeline, flags.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | enable low: FIFOs flushed, counters/pipeline zeroed
//   ST_SKIP | settling: popped pairs discarded, skip down-counter running
//   ST_RUN  | popped pairs feed the error pipeline and window accumulator
// -----------------------------------------------------------------------------
module demod_err_channel #(
  parameter int DATA_WIDTH  = 16,
  parameter int SIGNED_DATA = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int WINDOW_LOG2 = 7,
  parameter int SKIP_PAIRS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [2*DATA_WIDTH-1:0] threshold_msq_i,
  input  logic [DATA_WIDTH-1:0]   dut_data_i,
  input  logic                    dut_valid_i,
  input  logic [DATA_WIDTH-1:0]   ref_data_i,
  input  logic                    ref_valid_i,
  output logic [2*DATA_WIDTH-1:0] msq_o,
  output logic                    msq_valid_o,
  output logic                    fail_o,
  output logic                    overflow_o
);
  localparam int DW   = DATA_WIDTH;
  localparam int ACCW = 2*DW + WINDOW_LOG2;
  localparam int SKW  = (SKIP_PAIRS < 1) ? 1 : $clog2(SKIP_PAIRS + 1);
  localparam logic [SKW-1:0]         SKIP_LOAD = SKW'(SKIP_PAIRS);
  localparam logic [SKW-1:0]         SKIP_ONE  = SKW'(1);
  localparam logic [WINDOW_LOG2-1:0] PAIR_ONE  = WINDOW_LOG2'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_RUN} state_t;

  state_t state;
  state_t state_next;

  logic [DW-1:0] dut_head;
  logic [DW-1:0] ref_head;
  logic          dut_empty;
  logic          dut_full;
  logic          ref_empty;
  logic          ref_full;
  logic          active;
  logic          pop;
  logic          run_pop;
  logic          dut_push;
  logic          ref_push;
  logic          dut_drop;
  logic          ref_drop;

  logic [SKW-1:0]         skip_cnt;
  logic [WINDOW_LOG2-1:0] pair_cnt;
  logic                   pair_last;

  logic signed [DW:0] diff;
  logic signed [DW:0] e_q;
  logic               e_vld;
  logic               e_last;
  logic [DW:0]        e_neg;
  logic [DW-1:0]      e_mag;
  logic [2*DW-1:0]    sq_next;
  logic [2*DW-1:0]    sq_q;
  logic               sq_vld;
  logic               sq_last;
  logic [ACCW-1:0]    acc;
  logic               acc_last;
  logic [2*DW-1:0]    acc_msq;
  logic               fail_set;

  function automatic logic signed [DW:0] extend(input logic [DW-1:0] d);
    if (SIGNED_DATA != 0) return {d[DW-1], d};
    else                  return {1'b0, d};
  endfunction

  // enable_i is folded in so a drop takes effect on the very next edge.
  assign active  = enable_i && (state != ST_IDLE);
  assign pop     = active && !dut_empty && !ref_empty;
  assign run_pop = pop && (state == ST_RUN);

  assign dut_push = active && dut_valid_i && (!dut_full || pop);
  assign ref_push = active && ref_valid_i && (!ref_full || pop);
  assign dut_drop = active && dut_valid_i && dut_full && !pop;
  assign ref_drop = active && ref_valid_i && ref_full && !pop;

  demod_err_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_dut_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (!active),
    .push      (dut_push),
    .push_data (dut_data_i),
    .pop       (pop),
    .head      (dut_head),
    .empty     (dut_empty),
    .full      (dut_full)
  );

  demod_err_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (!active),
    .push      (ref_push),
    .push_data (ref_data_i),
    .pop       (pop),
    .head      (ref_head),
    .empty     (ref_empty),
    .full      (ref_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable_i) state_next = (SKIP_PAIRS == 0) ? ST_RUN : ST_SKIP;
      end
      ST_SKIP: begin
        if (!enable_i)                      state_next = ST_IDLE;
        else if (pop && skip_cnt == SKIP_ONE) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Settling and window counters both count down; the window counter wraps
  // from 0 back to all-ones, so windows follow each other without a gap.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      skip_cnt <= SKIP_LOAD;
      pair_cnt <= '1;
    end else begin
      if (pop && state == ST_SKIP) skip_cnt <= skip_cnt - SKIP_ONE;
      if (run_pop)                 pair_cnt <= pair_cnt - PAIR_ONE;
    end
  end

  assign pair_last = (pair_cnt == '0);
  assign diff      = extend(dut_head) - extend(ref_head);

  // |e| <= 2^DW-1, so squaring the DW-bit magnitude is exact in 2*DW bits.
  assign e_neg   = -e_q;
  assign e_mag   = e_q[DW] ? e_neg[DW-1:0] : e_q[DW-1:0];
  assign sq_next = {{DW{1'b0}}, e_mag} * {{DW{1'b0}}, e_mag};
  assign acc_msq = acc[ACCW-1:WINDOW_LOG2];

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      e_q         <= '0;
      e_vld       <= 1'b0;
      e_last      <= 1'b0;
      sq_q        <= '0;
      sq_vld      <= 1'b0;
      sq_last     <= 1'b0;
      acc         <= '0;
      acc_last    <= 1'b0;
      msq_valid_o <= 1'b0;
    end else begin
      e_q      <= run_pop ? diff : '0;
      e_vld    <= run_pop;
      e_last   <= run_pop && pair_last;
      sq_q     <= e_vld ? sq_next : '0;
      sq_vld   <= e_vld;
      sq_last  <= e_vld && e_last;
      acc_last <= sq_vld && sq_last;
      // On the cycle the finished sum is read out, the next window's first
      // square (if any) seeds the accumulator directly.
      if (acc_last)    acc <= sq_vld ? {{WINDOW_LOG2{1'b0}}, sq_q} : '0;
      else if (sq_vld) acc <= acc + {{WINDOW_LOG2{1'b0}}, sq_q};
      msq_valid_o <= acc_last;
    end
  end

  // msq_o holds the last completed window across IDLE periods.
  always_ff @(posedge clk) begin
    if (reset)                   msq_o <= '0;
    else if (active && acc_last) msq_o <= acc_msq;
  end

  assign fail_set = active && acc_last && (acc_msq > threshold_msq_i);

  // Set has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      fail_o     <= fail_set || (fail_o && !clear_i);
      overflow_o <= dut_drop || ref_drop || (overflow_o && !clear_i);
    end
  end
endmodule

// -----------------------------------------------------------------------------
// Top: one lane per channel plus the channel-0 window counter.
// -----------------------------------------------------------------------------
module demod_error_monitor #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int SIGNED_DATA  = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int WINDOW_LOG2  = 7,
  parameter int SKIP_PAIRS   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic [2*DATA_WIDTH-1:0]              threshold_msq_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   dut_data_i,
  input  logic [NUM_CHANNELS-1:0]              dut_valid_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ref_data_i,
  input  logic [NUM_CHANNELS-1:0]              ref_valid_i,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] msq_o,
  output logic [NUM_CHANNELS-1:0]              msq_valid_o,
  output logic [NUM_CHANNELS-1:0]              fail_o,
  output logic [NUM_CHANNELS-1:0]              overflow_o,
  output logic [15:0]                          window_count_o
);
  localparam int DW = DATA_WIDTH;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    demod_err_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SIGNED_DATA (SIGNED_DATA),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .WINDOW_LOG2 (WINDOW_LOG2),
      .SKIP_PAIRS  (SKIP_PAIRS)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .enable_i        (enable_i),
      .clear_i         (clear_i),
      .threshold_msq_i (threshold_msq_i),
      .dut_data_i      (dut_data_i[c*DW +: DW]),
      .dut_valid_i     (dut_valid_i[c]),
      .ref_data_i      (ref_data_i[c*DW +: DW]),
      .ref_valid_i     (ref_valid_i[c]),
      .msq_o           (msq_o[c*2*DW +: 2*DW]),
      .msq_valid_o     (msq_valid_o[c]),
      .fail_o          (fail_o[c]),
      .overflow_o      (overflow_o[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)               window_count_o <= '0;
    else if (msq_valid_o[0]) window_count_o <= window_count_o + 16'd1;
  end
endmodule

// File: doc/demod_error_monitor.md
# demod_error_monitor

Synthesizable multi-channel error monitor that aligns the sample streams of a demodulator under test and a reference demodulator, computes the mean-square error over fixed windows and flags threshold violations. It sits after the `quadrature_demod` outputs. It is used both in simulation and on-target, so the RMSE check for resolver channels runs in hardware without a testbench-side real-number model. Each channel is independent: it has its own alignment FIFOs, its own skip counter and its own accumulator.

## Interface
- NUM_CHANNELS, 2, number of independent channels (1..8)
- DATA_WIDTH, 16, sample width (DW)
- SIGNED_DATA, 1, 1 = two's-complement samples, 0 = unsigned
- FIFO_DEPTH, 16, per-stream alignment FIFO depth (power of two, ≥2)
- WINDOW_LOG2, 7, window length = 2^WINDOW_LOG2 sample pairs
- SKIP_PAIRS, 8, pairs discarded after enable rises (settling)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable_i  in  1  high = monitor runs; low = flush and idle
- clear_i  in  1  one-cycle pulse that clears the sticky flags
- threshold_msq_i  in  2*DW  mean-square threshold in LSB²
- dut_data_i  in  NUM_CHANNELS*DW  DUT samples, channel c at [c*DW +: DW]
- dut_valid_i  in  NUM_CHANNELS  DUT sample strobe per channel
- ref_data_i  in  NUM_CHANNELS*DW  reference samples
- ref_valid_i  in  NUM_CHANNELS  reference sample strobe
- msq_o  out  NUM_CHANNELS*2*DW  last completed window mean-square error
- msq_valid_o  out  NUM_CHANNELS  one-cycle pulse when msq_o is updated
- fail_o  out  NUM_CHANNELS  sticky: some window had msq > threshold
- overflow_o  out  NUM_CHANNELS  sticky: a sample was dropped on a full FIFO
- window_count_o  out  16  number of windows completed on channel 0 (wraps)

## Operation
- Per channel there are two FIFOs, DUT and REF, in first-word-fall-through mode.
  - A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the sample is dropped and overflow_o[c] is set.
- A pair is popped when both FIFOs of a channel are non-empty. Both FIFOs are always popped together, so the streams align in arrival order regardless of relative latency.
- Per-channel state machine:
  - IDLE (enable_i=0): FIFOs are flushed, counters and the accumulator are zeroed, and pushes are ignored. enable_i=1 moves to SKIP.
  - SKIP: popped pairs are discarded. After SKIP_PAIRS pops the state moves to RUN. If SKIP_PAIRS=0, the state goes directly to RUN.
  - RUN: popped pairs feed the error pipeline.
  - enable_i=0 in any state returns to IDLE next cycle. Any in-flight window is abandoned and produces no msq_valid_o.
- Arithmetic:
  - Samples are extended to DW+1 bits (sign- or zero-extended per SIGNED_DATA).
  - e = dut − ref, DW+1 bits signed, exact.
  - e² is at most (2^DW−1)², so it fits 2*DW bits unsigned.
  - The accumulator is 2*DW+WINDOW_LOG2 bits, unsigned, and never overflows within a window.
  - At window end: msq = acc >> WINDOW_LOG2 (truncation) and the accumulator restarts at 0. No saturation is needed.
- fail_o[c] is set when msq > threshold_msq_i, a strict compare evaluated in the msq_valid_o cycle.
- clear_i clears fail_o and overflow_o. If a set condition occurs in the same cycle as clear_i, set wins.
- window_count_o increments on msq_valid_o[0].

## Timing
- Reset values:
  - msq_o, msq_valid_o, fail_o, overflow_o and window_count_o are 0.
  - All state machines are in IDLE and the FIFOs are empty.
- A push at cycle t is visible to the pop logic at t+1.
- Error pipeline:
  - Pop at cycle p.
  - Error register at p+1.
  - Square register at p+2.
  - Accumulate at p+3.
  - For the last pair of a window, msq_o, msq_valid_o and the fail update occur at p+4.
- Throughput: one pair per cycle per channel. Back-to-back windows have no gap.
- Reset mid-operation clears everything within one cycle. Nothing already in the pipeline is emitted.
- While IDLE, the pipeline stages are zeroed and the valid chain is held low.

## Test plan
- Identical ramps on both streams of channel 0, WINDOW_LOG2=7, SKIP_PAIRS=8 -> first msq_valid_o after 136 pairs + 4 cycles, msq_o=0, fail_o=0.
- DUT = REF + 1 constant, threshold 1 -> msq_o=1, fail_o=0. With threshold 0 -> fail_o=1 at the first window, and it stays set until clear_i.
- REF delayed 5 cycles relative to DUT, identical data -> msq_o=0 and no overflow (FIFO_DEPTH=16).
- DUT pushed 17 times with no REF -> 16 stored, overflow_o[0]=1, channel 1 unaffected. clear_i then returns overflow_o to 0.
- enable_i dropped after 60 RUN pairs, then raised again -> no msq_valid_o for the abandoned window. SKIP repeats and the next window completes 136 pairs after re-enable.
- Error ±(2^DW−1) alternating (DW=16, SIGNED_DATA=1) -> msq_o=(2^16−1)²=4294836225, with no wrap in the accumulator.
